// File: rtl/pmem_line_responder.sv
// Line-granular physical memory responder for the 128-bit pmem bus.
// One request in flight; completion pulse after a fixed latency.
module pmem_line_responder #(
   parameter int LATENCY = 4,
   parameter int LINES   = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic         pmem_resp,
   output logic [127:0] pmem_rdata,
   output logic         busy,
   output logic         proto_error
);

   localparam int IW = $clog2(LINES);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t         state;
   logic [3:0]     cnt;
   logic           op_wr;
   logic [IW-1:0]  idx;
   logic [127:0]   wdata;
   logic [127:0]   mem [LINES];

   logic unused;
   assign unused = ^{pmem_address[15:IW+4], pmem_address[3:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         op_wr       <= 1'b0;
         idx         <= '0;
         wdata       <= '0;
         pmem_resp   <= 1'b0;
         pmem_rdata  <= '0;
         busy        <= 1'b0;
         proto_error <= 1'b0;
         for (int i = 0; i < LINES; i++) begin
            mem[i] <= '0;
         end
      end else begin
         pmem_resp   <= 1'b0;
         proto_error <= 1'b0;
         case (state)
            IDLE: begin
               if (pmem_read | pmem_write) begin
                  // a simultaneous read+write is served as a write
                  op_wr       <= pmem_write;
                  idx         <= pmem_address[IW+3:4];
                  wdata       <= pmem_wdata;
                  cnt         <= CNT_INIT;
                  proto_error <= pmem_read & pmem_write;
                  busy        <= 1'b1;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               // counter runs to zero so RESP lands LATENCY edges after acceptance
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  pmem_resp <= 1'b1;
                  if (op_wr) begin
                     mem[idx] <= wdata;
                  end else begin
                     pmem_rdata <= mem[idx];
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: vector table plus scoreboard of read data,
// and hand sequences for back-to-back, reset mid-request and LATENCY=1.
module tb_pmem_line_responder;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp, busy, proto_error;
   logic [127:0] pmem_rdata;

   logic         r1, w1;
   logic [15:0]  a1;
   logic [127:0] d1;
   logic         resp1, busy1, perr1;
   logic [127:0] rdata1;

   always #5 clk = ~clk;

   pmem_line_responder #(.LATENCY(LAT), .LINES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .busy(busy), .proto_error(proto_error)
   );

   pmem_line_responder #(.LATENCY(1), .LINES(16)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .pmem_read(r1), .pmem_write(w1),
      .pmem_address(a1), .pmem_wdata(d1),
      .pmem_resp(resp1), .pmem_rdata(rdata1),
      .busy(busy1), .proto_error(perr1)
   );

   int tests = 0;
   int fails = 0;
   logic [127:0] sb[$];
   logic [127:0] last_rd = '0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && pmem_resp) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 128'(pmem_resp), 128'd0);
         end else begin
            chk("rdata", pmem_rdata, sb.pop_front());
         end
      end
   end

   typedef struct {
      logic         rd;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] data;
      logic [127:0] exp;
      logic         perr;
      logic         drop;
   } vec_t;

   localparam logic [127:0] DV = 128'hDEADBEEF_00112233_44556677_8899AABB;
   localparam logic [127:0] AV = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
   localparam logic [127:0] BV = 128'hBBBB1111_2222BBBB_3333CCCC_0000BBBB;
   localparam logic [127:0] CV = 128'hC0C0C0C0_12345678_9ABCDEF0_0F0F0F0F;
   localparam logic [127:0] EV = 128'hE1E2E3E4_E5E6E7E8_E9EAEBEC_EDEEEFF0;
   localparam logic [127:0] GV = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

   vec_t tbl[11];

   task automatic do_req(input vec_t v);
      int k;
      int bcnt;
      bit got;
      @(posedge clk); #1;
      pmem_read    = v.rd;
      pmem_write   = v.wr;
      pmem_address = v.addr;
      pmem_wdata   = v.data;
      if (v.wr) begin
         sb.push_back(last_rd);
      end else begin
         sb.push_back(v.exp);
         last_rd = v.exp;
      end
      @(posedge clk);
      k = 0;
      bcnt = 0;
      got = 0;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (k == 1) chk("proto_error", 128'(proto_error), 128'(v.perr));
         if (v.drop && k == 1) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
         end
         if (busy) bcnt++;
         if (pmem_resp) begin
            got = 1;
            chk("latency", 128'(k), 128'(LAT + 1));
         end
      end
      if (!got) chk("resp_timeout", 128'(got), 128'd1);
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      chk("busy_cycles", 128'(bcnt), 128'(LAT + 1));
      @(negedge clk);
      chk("busy_low", 128'(busy), 128'd0);
      chk("resp_one_cycle", 128'(pmem_resp), 128'd0);
   endtask

   task automatic do1(input logic wr, input logic [15:0] a,
                      input logic [127:0] d, input logic [127:0] exp);
      @(posedge clk); #1;
      r1 = ~wr;
      w1 = wr;
      a1 = a;
      d1 = d;
      @(posedge clk);
      @(negedge clk);
      chk("l1_resp_k1", 128'(resp1), 128'd0);
      chk("l1_busy_k1", 128'(busy1), 128'd1);
      @(negedge clk);
      chk("l1_resp_k2", 128'(resp1), 128'd1);
      chk("l1_rdata", rdata1, exp);
      r1 = 1'b0;
      w1 = 1'b0;
      @(negedge clk);
      chk("l1_busy_low", 128'(busy1), 128'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      pmem_read = 1'b0; pmem_write = 1'b0;
      pmem_address = '0; pmem_wdata = '0;
      r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;

      tbl[0]  = '{1, 0, 16'h0040, '0, '0, 0, 0};
      tbl[1]  = '{0, 1, 16'h0120, DV, '0, 0, 0};
      tbl[2]  = '{1, 0, 16'h012E, '0, DV, 0, 0};
      tbl[3]  = '{0, 1, 16'h0010, AV, '0, 0, 0};
      tbl[4]  = '{0, 1, 16'h0110, BV, '0, 0, 0};
      tbl[5]  = '{1, 0, 16'h0010, '0, BV, 0, 0};
      tbl[6]  = '{1, 1, 16'h0200, CV, '0, 1, 0};
      tbl[7]  = '{1, 0, 16'h0200, '0, CV, 0, 0};
      tbl[8]  = '{0, 1, 16'h00F0, EV, '0, 0, 1};
      tbl[9]  = '{1, 0, 16'hF0F4, '0, EV, 0, 0};
      tbl[10] = '{1, 0, 16'h0110, '0, BV, 0, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp", 128'(pmem_resp), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_perr", 128'(proto_error), 128'd0);
      chk("rst_rdata", pmem_rdata, 128'd0);
      rst_n = 1'b1;

      foreach (tbl[i]) do_req(tbl[i]);

      // back-to-back reads with pmem_read held through RESP
      @(posedge clk); #1;
      pmem_read = 1'b1;
      pmem_address = 16'h0120;
      sb.push_back(DV);
      sb.push_back(DV);
      last_rd = DV;
      @(posedge clk);
      n = 0;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         chk("b2b_resp", 128'(pmem_resp),
             128'((k == LAT + 1) || (k == 2 * LAT + 3)));
         if (pmem_resp) n++;
         if (k == 2 * LAT + 3) pmem_read = 1'b0;
      end
      chk("b2b_count", 128'(n), 128'd2);

      // reset two cycles into a write
      @(posedge clk); #1;
      pmem_write = 1'b1;
      pmem_address = 16'h0300;
      pmem_wdata = GV;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_resp", 128'(pmem_resp), 128'd0);
      chk("mid_rst_busy", 128'(busy), 128'd0);
      chk("mid_rst_perr", 128'(proto_error), 128'd0);
      chk("mid_rst_rdata", pmem_rdata, 128'd0);
      pmem_write = 1'b0;
      sb.delete();
      last_rd = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_req('{1, 0, 16'h0300, '0, '0, 0, 0});
      do_req('{1, 0, 16'h0120, '0, '0, 0, 0});

      // single-cycle latency instance
      do1(1'b1, 16'h0050, GV, 128'd0);
      do1(1'b0, 16'h0050, '0, GV);

      repeat (2) @(posedge clk);
      chk("sb_empty", 128'(sb.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
